// File: rtl/mnet_pkg.sv
// mnet_pkg: shared MobileNet datapath widths, GAP sequencer state type and the per-beat lane sum helper
package mnet_pkg;
  localparam int DATA_W = 10;
  localparam int LANES = 9;
  localparam int SUM_W = DATA_W + 4;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} gap_state_t;
  function automatic logic [SUM_W-1:0] lane_sum(input logic [LANES*DATA_W-1:0] beat);
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + SUM_W'(beat[k*DATA_W +: DATA_W]);
  endfunction
endpackage

// File: rtl/gap_accum.sv
// gap_accum: saturating accumulator of lane sums (i_clk, i_reset async low, clr/en/beat in, acc out; clr wins over en)
module gap_accum
  import mnet_pkg::*;
#(
  parameter int ACC_W = 22
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic [LANES*DATA_W-1:0] beat,
  output logic [ACC_W-1:0]        acc
);
  localparam int W = (ACC_W > SUM_W ? ACC_W : SUM_W) + 1;
  logic [W-1:0] sum;
  assign sum = W'(acc) + W'(lane_sum(beat));
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= |sum[W-1:ACC_W] ? '1 : sum[ACC_W-1:0];
endmodule

// File: rtl/gap_sequencer.sv
// gap_sequencer: global-average-pool sequencer; beats in (valid/ready), one scaled average per channel out (valid/ready), busy/done status
module gap_sequencer #(
  parameter int DATA_W       = 10,
  parameter int LANES        = 9,
  parameter int ACC_W        = 22,
  parameter int SHIFT        = 12,
  parameter int BEATS_PER_CH = 455,
  parameter int NUM_CH       = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_in_valid,
  input  logic [LANES*DATA_W-1:0]   i_in_data,
  output logic                      o_in_ready,
  output logic                      o_out_valid,
  output logic [DATA_W-1:0]         o_out_data,
  output logic [$clog2(NUM_CH)-1:0] o_out_ch,
  input  logic                      i_out_ready,
  output logic                      o_busy,
  output logic                      o_done
);
  import mnet_pkg::*;
  localparam int BW = BEATS_PER_CH > 1 ? $clog2(BEATS_PER_CH) : 1;
  localparam int CW = $clog2(NUM_CH);
  gap_state_t state, nxt;
  logic [BW-1:0] beat;
  logic [ACC_W-1:0] acc;
  logic take, last_beat, emit_hs, last_ch, begin_frame, unused_acc;
  assign take = state == ACCUM && i_in_valid;
  assign last_beat = beat == BW'(BEATS_PER_CH - 1);
  assign emit_hs = state == EMIT && i_out_ready;
  assign last_ch = o_out_ch == CW'(NUM_CH - 1);
  assign begin_frame = state == IDLE && i_start;
  assign o_out_data = acc[SHIFT+DATA_W-1:SHIFT];
  assign unused_acc = ^acc;
  gap_accum #(.ACC_W(ACC_W)) u_acc (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .clr    (begin_frame || emit_hs),
    .en     (take),
    .beat   (i_in_data),
    .acc    (acc)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    o_in_ready = state == ACCUM;
    o_out_valid = state == EMIT;
    o_busy = state != IDLE;
    o_done = state == DONE;
    nxt = state;
    case (state)
      IDLE:    nxt = i_start ? ACCUM : IDLE;
      ACCUM:   nxt = take && last_beat ? EMIT : ACCUM;
      EMIT:    nxt = !i_out_ready ? EMIT : last_ch ? DONE : ACCUM;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      beat <= '0;
      o_out_ch <= '0;
    end else begin
      beat <= begin_frame || emit_hs ? '0 : take ? beat + BW'(1) : beat;
      o_out_ch <= begin_frame ? '0 : emit_hs && !last_ch ? o_out_ch + CW'(1) : o_out_ch;
    end
endmodule

// File: tb/tb_gap_sequencer.sv
// tb_gap_sequencer: scoreboard bench over three configurations of gap_sequencer
module tb_gap_sequencer;
  typedef struct {int data; int ch;} exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic ab_start, ab_valid, a_ready, b_ready;
  logic [89:0] ab_data;
  logic a_in_ready, a_out_valid, a_busy, a_done;
  logic [9:0] a_out_data, a_out_ch;
  logic b_in_ready, b_out_valid, b_busy, b_done;
  logic [9:0] b_out_data, b_out_ch;
  logic c_start, c_valid, c_ready;
  logic [89:0] c_data;
  logic c_in_ready, c_out_valid, c_busy, c_done;
  logic [9:0] c_out_data;
  logic [1:0] c_out_ch;
  int checks = 0, errors = 0;
  exp_t qa[$], qb[$], qc[$];
  bit stall = 0, c_fin = 0, c_wait = 0;
  int c_done_cnt = 0, wcnt = 0;
  logic [9:0] c_pd;
  logic [1:0] c_pc;

  gap_sequencer u_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(ab_start), .i_in_valid(ab_valid), .i_in_data(ab_data),
    .o_in_ready(a_in_ready), .o_out_valid(a_out_valid), .o_out_data(a_out_data), .o_out_ch(a_out_ch),
    .i_out_ready(a_ready), .o_busy(a_busy), .o_done(a_done));
  gap_sequencer #(.BEATS_PER_CH(456)) u_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(ab_start), .i_in_valid(ab_valid), .i_in_data(ab_data),
    .o_in_ready(b_in_ready), .o_out_valid(b_out_valid), .o_out_data(b_out_data), .o_out_ch(b_out_ch),
    .i_out_ready(b_ready), .o_busy(b_busy), .o_done(b_done));
  gap_sequencer #(.BEATS_PER_CH(2), .NUM_CH(3), .SHIFT(2), .ACC_W(12)) u_c (
    .i_clk(clk), .i_reset(rst_n), .i_start(c_start), .i_in_valid(c_valid), .i_in_data(c_data),
    .o_in_ready(c_in_ready), .o_out_valid(c_out_valid), .o_out_data(c_out_data), .o_out_ch(c_out_ch),
    .i_out_ready(c_ready), .o_busy(c_busy), .o_done(c_done));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_ready) begin
        if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", a_out_data, e.data);
          chk("a_ch", a_out_ch, e.ch);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid && b_ready) begin
        if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", b_out_data, e.data);
          chk("b_ch", b_out_ch, e.ch);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (c_fin || c_done) chk("c_done_timing", c_done, c_fin);
      c_done_cnt += c_done;
      c_fin = 0;
      if (rst_n && c_out_valid) begin
        chk("c_in_ready_in_emit", c_in_ready, 0);
        if (c_wait) begin
          chk("c_hold_data", c_out_data, c_pd);
          chk("c_hold_ch", c_out_ch, c_pc);
        end
        if (c_ready) begin
          c_wait = 0;
          if (qc.size() == 0) chk("c_unexpected_out", 1, 0);
          else begin
            e = qc.pop_front();
            chk("c_data", c_out_data, e.data);
            chk("c_ch", c_out_ch, e.ch);
            c_fin = e.ch == 2;
          end
        end else begin
          c_wait = 1;
          c_pd = c_out_data;
          c_pc = c_out_ch;
        end
      end else c_wait = 0;
    end
  end

  initial begin
    c_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      wcnt = c_out_valid ? wcnt + 1 : 0;
      c_ready = !stall || wcnt > 5;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic ab_go();
    ab_start = 1;
    @(posedge clk);
    #1;
    ab_start = 0;
  endtask

  task automatic ab_run(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      ab_valid = 1;
      ab_data = {9{10'(v)}};
      @(negedge clk);
      if (i == 454) chk("a_valid_before_last", a_out_valid, 0);
      if (i == 455) chk("a_valid_after_last", a_out_valid, 1);
      @(posedge clk);
      #1;
    end
    ab_valid = 0;
  endtask

  task automatic rst_pulse();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic c_beat(input int v);
    c_valid = 1;
    c_data = {9{10'(v)}};
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (c_in_ready) begin
        @(posedge clk);
        #1;
        c_valid = 0;
        return;
      end
    end
    c_valid = 0;
    chk("c_beat_timeout", 0, 1);
  endtask

  task automatic c_frame(input bit gaps, input bit pulse);
    qc.push_back('{data: 4, ch: 0});
    qc.push_back('{data: 9, ch: 1});
    qc.push_back('{data: 13, ch: 2});
    c_done_cnt = 0;
    c_start = 1;
    @(posedge clk);
    #1;
    c_start = 0;
    for (int ch = 0; ch < 3; ch++)
      for (int b = 0; b < 2; b++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin
          c_valid = 0;
          @(posedge clk);
          #1;
        end
        c_start = pulse && ch == 1 && b == 0;
        c_beat(ch + 1);
        c_start = 0;
        if (pulse && ch == 0 && b == 1) begin
          c_start = 1;
          @(posedge clk);
          #1;
          c_start = 0;
        end
      end
    for (int n = 0; n < 100 && c_busy; n++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("c_idle_after_frame", c_busy, 0);
    chk("c_done_count", c_done_cnt, 1);
    chk("c_queue_drained", qc.size(), 0);
  endtask

  initial begin
    rst_n = 0;
    ab_start = 0; ab_valid = 0; ab_data = '0; a_ready = 1; b_ready = 1;
    c_start = 0; c_valid = 0; c_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_done", a_done, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_ch", a_out_ch, 0);
    chk("rst_c_busy", c_busy, 0);
    @(posedge clk);
    #1;
    ab_go();
    @(negedge clk);
    chk("start_in_ready", a_in_ready, 1);
    chk("start_busy", a_busy, 1);
    @(posedge clk);
    #1;
    ab_run(1023, 3);
    @(negedge clk);
    chk("a_partial", a_out_data, 6);
    rst_n = 0;
    #1;
    chk("async_rst_busy", a_busy, 0);
    chk("async_rst_data", a_out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    qa.push_back('{data: 0, ch: 0});
    qb.push_back('{data: 1, ch: 0});
    ab_go();
    ab_run(1, 456);
    repeat (5) @(posedge clk);
    #1;
    chk("qa_drained_1", qa.size(), 0);
    chk("qb_drained_1", qb.size(), 0);
    rst_pulse();
    qa.push_back('{data: 1022, ch: 0});
    qb.push_back('{data: 1023, ch: 0});
    ab_go();
    ab_run(1023, 456);
    repeat (5) @(posedge clk);
    #1;
    chk("qa_drained_2", qa.size(), 0);
    chk("qb_drained_2", qb.size(), 0);
    rst_pulse();
    c_frame(0, 0);
    stall = 1;
    c_frame(1, 0);
    stall = 0;
    c_frame(0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gap_sequencer.md
# gap_sequencer

Global-average-pool sequencer for the MobileNet classifier head. It accepts a channel-major stream of 9-lane pixel beats from the feature-map buffer and accumulates `BEATS_PER_CH` beats per channel into a saturating accumulator. It emits one scaled 10-bit average per channel on a valid/ready port, walks all `NUM_CH` channels per `i_start`, and then signals completion. It sits between the last depthwise/pointwise stage buffer and the fully-connected layer.

## Interface
- `DATA_W`, 10, lane and result width
- `LANES`, 9, pixels per input beat
- `ACC_W`, 22, accumulator width; must satisfy `ACC_W >= SHIFT + DATA_W`
- `SHIFT`, 12, right-shift applied to the accumulator (divide by 2^SHIFT)
- `BEATS_PER_CH`, 455, beats per channel (455 × 9 = 4095 pixels; zero-padded lanes by upstream)
- `NUM_CH`, 1024, channels per frame
- `i_clk` in 1: clock
- `i_reset` in 1: asynchronous, active-low reset
- `i_start` in 1: begin a frame; sampled only in IDLE
- `i_in_valid` in 1: input beat valid
- `i_in_data` in `LANES*DATA_W`: lane k at bits `[k*DATA_W +: DATA_W]`
- `o_in_ready` out 1: beat accepted when `i_in_valid && o_in_ready`
- `o_out_valid` out 1: average valid
- `o_out_data` out `DATA_W`: `acc[SHIFT+DATA_W-1:SHIFT]`
- `o_out_ch` out `$clog2(NUM_CH)`: channel index of `o_out_data`
- `i_out_ready` in 1: downstream accepts result
- `o_busy` out 1: high in any state other than IDLE
- `o_done` out 1: one-cycle pulse after the last channel is accepted

## Operation
- States: IDLE, ACCUM, EMIT, DONE.
- IDLE → ACCUM on `i_start`. Entering ACCUM clears the accumulator, beat counter and channel counter.
- ACCUM: `o_in_ready = 1`. Each accepted beat sets `acc <= sat(acc + Σ lanes)`.
  - Lane sum is unsigned and `DATA_W + 4` bits wide.
  - `sat` clamps at 2^ACC_W − 1. The saturated value is held for the rest of that channel.
  - The beat counter increments on each accepted beat. The beat accepted at count `BEATS_PER_CH − 1` moves the block to EMIT; that beat's sum is included in the accumulator.
- EMIT: `o_in_ready = 0`, `o_out_valid = 1`. Data and channel are held stable until `i_out_ready`. On handshake:
  - The accumulator and beat counter clear.
  - If `ch == NUM_CH − 1`, go to DONE. Otherwise increment `ch` and go to ACCUM.
- DONE: `o_done = 1` for one cycle, then go to IDLE.
- `i_start` outside IDLE is ignored. `i_in_valid` outside ACCUM is ignored; no beat is consumed.
- Reset (asynchronous, at any time, including mid-channel) returns all state to reset values. Partial sums are discarded.

## Timing
- Reset values: state IDLE; `o_in_ready`, `o_out_valid`, `o_busy`, `o_done` = 0; `o_out_data` = 0; `o_out_ch` = 0; accumulator and counters = 0.
- `i_start` at cycle t: ACCUM and `o_in_ready = 1` at t+1.
- Throughput in ACCUM is one beat per cycle; bubbles on `i_in_valid` are allowed.
- Last beat accepted at cycle t: `o_out_valid = 1` at t+1 with the final value.
- EMIT handshake at cycle t:
  - Non-final channel: `o_in_ready = 1` at t+1. Channel overhead is 1 cycle plus backpressure.
  - Final channel: `o_done` high at t+1, IDLE at t+2.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `i_in_valid` or `i_out_ready` to any output.

## Structure
- Shared package `mnet_pkg` holds:
  - `DATA_W` and `LANES` (common with the conv datapath);
  - the `gap_state_t` enum (IDLE, ACCUM, EMIT, DONE);
  - a `lane_sum` function.
- One sub-module, `gap_accum`, contains the ACC_W saturating accumulator. Its inputs are clear, enable and the 9-lane beat; its output is the accumulator value.
- The FSM and the beat/channel counters live in `gap_sequencer`.

## Test plan
- Reset mid-ACCUM after 3 beats, then `i_start` with 455 beats of lanes = 1 → `o_out_data` = 0 (4095 >> 12); prior partial sum absent.
- Defaults, all lanes 1023 for 455 beats → sum 4189185, `o_out_data` = 1022, `o_out_ch` = 0, `o_out_valid` 1 cycle after the last beat.
- `BEATS_PER_CH` = 456, all lanes 1023 → accumulator saturates at 4194303, `o_out_data` = 1023, no wrap.
- `BEATS_PER_CH` = 2, `NUM_CH` = 3, `SHIFT` = 2, `ACC_W` = 12, lanes = 1, 2, 3 per channel → outputs 4, 9, 13 on channels 0, 1, 2. `o_done` pulses once, 1 cycle after the channel-2 handshake.
- Same configuration with `i_out_ready` held low 5 cycles in EMIT and random `i_in_valid` gaps → `o_in_ready` = 0 during EMIT, data/channel stable, results unchanged.
- `i_start` pulsed during ACCUM and EMIT → ignored; channel count and `o_done` unaffected.
